adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_core.sv | 20 ++
 rtl/adder_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared state type and default sizing for adder_arbiter
// Revision  : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int DEF_W    = 2;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/adder_core.sv
// ============================================================================
// adder_core : combinational W-bit adder with carry out
// Revision   : 1.0
// ============================================================================
`default_nettype none

module adder_core #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         carry
);

    assign {carry, y} = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter : round-robin arbiter sharing one adder among NREQ requesters
// Revision      : 1.0
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic              busy
);

    state_e           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic [IDW-1:0]   id_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic             rsp_valid_q;

    logic             any_req;
    logic [IDW-1:0]   grant;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     core_y;
    logic             core_carry;

    // First set request at or after ptr, wrapping from NREQ-1 back to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] g;
        logic           found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && v[idx]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        any_req   = |req_valid;
        grant     = rr_pick(req_valid, rr_ptr_q);
        rr_ptr_d  = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        req_ready = '0;
        if (state_q == IDLE && any_req) begin
            req_ready[grant] = 1'b1;
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    adder_core #(
        .W (W)
    ) u_adder_core (
        .a     (a_q),
        .b     (b_q),
        .y     (core_y),
        .carry (core_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Any valid request is granted, so a handshake is implied.
                    if (any_req) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        id_q     <= grant;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    sum_q       <= core_y;
                    carry_q     <= core_carry;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter : self-checking bench for adder_arbiter (NREQ=4, W=2)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              busy;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] sum;
        logic       carry;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic single_op(input vec_t v);
        req_valid = '0;
        req_valid[v.idx] = 1'b1;
        req_a[v.idx*W +: W] = v.a;
        req_b[v.idx*W +: W] = v.b;
        rsp_ready = 1'b0;
        sample();
        chk("tbl_req_ready", 32'(req_ready), 32'(1 << v.idx));
        next_cycle();
        req_valid = '0;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        sample();
        chk("tbl_calc_valid", 32'(rsp_valid), 32'd0);
        chk("tbl_calc_busy", 32'(busy), 32'd1);
        next_cycle();
        rsp_ready = 1'b1;
        sample();
        chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tbl_rsp_id", 32'(rsp_id), 32'(v.idx));
        chk("tbl_rsp_sum", 32'(rsp_sum), 32'(v.sum));
        chk("tbl_rsp_carry", 32'(rsp_carry), 32'(v.carry));
        next_cycle();
        rsp_ready = 1'b0;
        sample();
        chk("tbl_idle_valid", 32'(rsp_valid), 32'd0);
        chk("tbl_idle_busy", 32'(busy), 32'd0);
        next_cycle();
    endtask

    // Reference model state: transaction level, time-stamped response.
    bit        m_idle;
    bit        m_pending;
    int        m_ptr;
    int        m_resp_at;
    int        m_id;
    int        m_sum;
    int        m_carry;

    initial begin
        int k;
        int last_cyc;
        int cyc;

        tbl[0] = '{idx: 2, a: 2'd1, b: 2'd1, sum: 2'd2, carry: 1'b0};
        tbl[1] = '{idx: 0, a: 2'd3, b: 2'd3, sum: 2'd2, carry: 1'b1};
        tbl[2] = '{idx: 1, a: 2'd2, b: 2'd1, sum: 2'd3, carry: 1'b0};
        tbl[3] = '{idx: 3, a: 2'd0, b: 2'd0, sum: 2'd0, carry: 1'b0};
        tbl[4] = '{idx: 2, a: 2'd3, b: 2'd1, sum: 2'd0, carry: 1'b1};
        tbl[5] = '{idx: 1, a: 2'd2, b: 2'd2, sum: 2'd0, carry: 1'b1};

        do_reset();
        sample();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            single_op(tbl[i]);
        end

        // Continuous requests: ids rotate 0,1,2,3,0 with a 3-cycle interval.
        do_reset();
        req_valid = '1;
        req_a     = 8'h1B;
        req_b     = 8'h6C;
        rsp_ready = 1'b1;
        k = 0;
        last_cyc = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            sample();
            if (rsp_valid) begin
                chk("rr_id", 32'(rsp_id), 32'(k % NREQ));
                if (k > 0) chk("rr_interval", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                k++;
            end
            next_cycle();
        end
        if (k < 5) begin
            errors++;
            $display("FAIL rr_timeout got=%0d results required=5", k);
        end

        // Consumer stall: outputs hold and no grants while pending.
        do_reset();
        req_valid = 4'b0010;
        req_a = '0;
        req_b = '0;
        req_a[1*W +: W] = 2'd1;
        req_b[1*W +: W] = 2'd2;
        next_cycle();
        req_valid = '1;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_id", 32'(rsp_id), 32'd1);
            chk("stall_sum", 32'(rsp_sum), 32'd3);
            chk("stall_carry", 32'(rsp_carry), 32'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        sample();
        chk("stall_release_grant", 32'(req_ready), 32'b0100);

        // Operand change after the handshake; rsp_ready held high outside RESP.
        do_reset();
        req_valid = 4'b0001;
        req_a = '0;
        req_b = '0;
        req_a[0 +: W] = 2'd1;
        req_b[0 +: W] = 2'd2;
        rsp_ready = 1'b1;
        next_cycle();
        req_valid = '0;
        req_a[0 +: W] = 2'd3;
        req_b[0 +: W] = 2'd3;
        sample();
        chk("latch_calc_busy", 32'(busy), 32'd1);
        next_cycle();
        sample();
        chk("latch_valid", 32'(rsp_valid), 32'd1);
        chk("latch_sum", 32'(rsp_sum), 32'd3);
        chk("latch_carry", 32'(rsp_carry), 32'd0);
        next_cycle();

        // Asynchronous reset during RESP.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        next_cycle();
        req_valid = '0;
        next_cycle();
        sample();
        chk("arst_pre_valid", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        req_valid = '1;
        sample();
        chk("arst_grant0", 32'(req_ready), 32'b0001);

        // Randomized traffic against the reference model.
        do_reset();
        m_idle = 1'b1;
        m_pending = 1'b0;
        m_ptr = 0;
        m_resp_at = 0;
        m_id = 0;
        m_sum = 0;
        m_carry = 0;
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            int g;
            bit exp_rv;
            logic [NREQ-1:0] exp_rr;
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            sample();
            exp_rr = '0;
            g = -1;
            if (m_idle && req_valid != 0) begin
                for (int s = 0; s < NREQ; s++) begin
                    if (g < 0 && req_valid[(m_ptr + s) % NREQ]) g = (m_ptr + s) % NREQ;
                end
                exp_rr[g] = 1'b1;
            end
            exp_rv = m_pending && (cyc >= m_resp_at);
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rr));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rnd_busy", 32'(busy), 32'(!m_idle));
            if (exp_rv) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rnd_rsp_sum", 32'(rsp_sum), 32'(m_sum));
                chk("rnd_rsp_carry", 32'(rsp_carry), 32'(m_carry));
            end
            if (g >= 0) begin
                int s;
                s = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
                m_idle    = 1'b0;
                m_pending = 1'b1;
                m_resp_at = cyc + 2;
                m_ptr     = (g + 1) % NREQ;
                m_id      = g;
                m_sum     = s % (1 << W);
                m_carry   = s / (1 << W);
            end else if (exp_rv && rsp_ready) begin
                m_idle    = 1'b1;
                m_pending = 1'b0;
            end
            cyc++;
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
